// File: rtl/kmeans_collect_pkg.sv
// Shared types and default widths for the k-means result collector.
// Optional drop counter is enabled with `define KMEANS_COLLECT_DROP_CNT_EN.
package kmeans_collect_pkg;

   localparam int DEF_IDX_W   = 16;
   localparam int DEF_COORD_W = 64;
   localparam int DEF_CNT_W   = 16;
   localparam int DEF_TAG_W   = 4;
   localparam int DEF_SUM_W   = DEF_COORD_W + DEF_CNT_W;

   typedef enum logic {
      ACCUM = 1'b0,
      DRAIN = 1'b1
   } collect_state_t;

   // One summary beat at the default widths.
   typedef struct packed {
      logic [DEF_IDX_W-1:0]        idx;
      logic signed [DEF_SUM_W-1:0] sum_x;
      logic signed [DEF_SUM_W-1:0] sum_y;
      logic signed [DEF_SUM_W-1:0] sum_z;
      logic [DEF_CNT_W-1:0]        count;
      logic                        last;
      logic [DEF_TAG_W-1:0]        tag;
   } summary_beat_t;

endpackage

// File: rtl/kmeans_centroid_acc.sv
// One centroid accumulator entry: three wrapping signed sums and a saturating count.
module kmeans_centroid_acc
   import kmeans_collect_pkg::*;
#(
   parameter int COORD_W = DEF_COORD_W,
   parameter int CNT_W   = DEF_CNT_W,
   parameter int SUM_W   = COORD_W + CNT_W
)
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clr,
   input  logic                     add_en,
   input  logic [COORD_W-1:0]       x,
   input  logic [COORD_W-1:0]       y,
   input  logic [COORD_W-1:0]       z,
   output logic signed [SUM_W-1:0]  sum_x,
   output logic signed [SUM_W-1:0]  sum_y,
   output logic signed [SUM_W-1:0]  sum_z,
   output logic [CNT_W-1:0]         count,
   output logic                     sat
);

   logic signed [SUM_W-1:0] sx_q, sx_d;
   logic signed [SUM_W-1:0] sy_q, sy_d;
   logic signed [SUM_W-1:0] sz_q, sz_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;

   assign sat = &cnt_q;

   always_comb begin
      sx_d  = sx_q;
      sy_d  = sy_q;
      sz_d  = sz_q;
      cnt_d = cnt_q;
      if (clr) begin
         sx_d  = '0;
         sy_d  = '0;
         sz_d  = '0;
         cnt_d = '0;
      end else if (add_en && !sat) begin
         // Sign-extend each coordinate; the sum wraps modulo 2^SUM_W.
         sx_d  = sx_q + SUM_W'($signed(x));
         sy_d  = sy_q + SUM_W'($signed(y));
         sz_d  = sz_q + SUM_W'($signed(z));
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sx_q  <= '0;
         sy_q  <= '0;
         sz_q  <= '0;
         cnt_q <= '0;
      end else begin
         sx_q  <= sx_d;
         sy_q  <= sy_d;
         sz_q  <= sz_d;
         cnt_q <= cnt_d;
      end
   end

   assign sum_x = sx_q;
   assign sum_y = sy_q;
   assign sum_z = sz_q;
   assign count = cnt_q;

endmodule

// File: rtl/kmeans_result_collector.sv
// Accumulates classified points per centroid and drains one summary beat per entry on the end marker.
// Macro KMEANS_COLLECT_DROP_CNT_EN enables the saturating drop counter (tied to 0 otherwise).
module kmeans_result_collector
   import kmeans_collect_pkg::*;
#(
   parameter int NUM_CENTROIDS = 8,
   parameter int IDX_W         = DEF_IDX_W,
   parameter int COORD_W       = DEF_COORD_W,
   parameter int CNT_W         = DEF_CNT_W,
   parameter int SUM_W         = COORD_W + CNT_W,
   parameter int TAG_W         = DEF_TAG_W
)
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_bits_centeroidsFinished,
   input  logic                     in_bits_pointsFinished,
   input  logic [IDX_W-1:0]         in_bits_centeroidIndex,
   input  logic [COORD_W-1:0]       in_bits_point_x,
   input  logic [COORD_W-1:0]       in_bits_point_y,
   input  logic [COORD_W-1:0]       in_bits_point_z,
   input  logic [TAG_W-1:0]         in_tag,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [IDX_W-1:0]         out_bits_centeroidIndex,
   output logic signed [SUM_W-1:0]  out_bits_sum_x,
   output logic signed [SUM_W-1:0]  out_bits_sum_y,
   output logic signed [SUM_W-1:0]  out_bits_sum_z,
   output logic [CNT_W-1:0]         out_bits_count,
   output logic                     out_bits_last,
   output logic [TAG_W-1:0]         out_tag,
   output logic [15:0]              drop_count
);

   localparam int PTR_W = (NUM_CENTROIDS > 1) ? $clog2(NUM_CENTROIDS) : 1;

   collect_state_t     state_q, state_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [TAG_W-1:0]   tag_q, tag_d;

   logic               draining;
   logic               in_hs, pt_beat, out_hs, is_last;
   logic [NUM_CENTROIDS-1:0] hit, sat, add_en, clr;

   logic signed [SUM_W-1:0] acc_sx [NUM_CENTROIDS];
   logic signed [SUM_W-1:0] acc_sy [NUM_CENTROIDS];
   logic signed [SUM_W-1:0] acc_sz [NUM_CENTROIDS];
   logic [CNT_W-1:0]        acc_cnt [NUM_CENTROIDS];

   // Handshake controls depend only on registered state, never on in_valid/out_ready.
   assign draining = (state_q == DRAIN);
   assign in_ready = ~draining;
   assign out_valid = draining;
   assign in_hs    = in_valid & in_ready;
   assign pt_beat  = in_hs & ~in_bits_pointsFinished & ~in_bits_centeroidsFinished;
   assign out_hs   = out_valid & out_ready;
   assign is_last  = (ptr_q == PTR_W'(NUM_CENTROIDS - 1));

   for (genvar gi = 0; gi < NUM_CENTROIDS; gi++) begin : g_acc
      assign hit[gi]    = (in_bits_centeroidIndex == IDX_W'(gi));
      assign add_en[gi] = pt_beat & hit[gi] & ~sat[gi];
      assign clr[gi]    = out_hs & (ptr_q == PTR_W'(gi));

      kmeans_centroid_acc #(
         .COORD_W (COORD_W),
         .CNT_W   (CNT_W),
         .SUM_W   (SUM_W)
      ) u_acc (
         .clk    (clk),
         .reset  (reset),
         .clr    (clr[gi]),
         .add_en (add_en[gi]),
         .x      (in_bits_point_x),
         .y      (in_bits_point_y),
         .z      (in_bits_point_z),
         .sum_x  (acc_sx[gi]),
         .sum_y  (acc_sy[gi]),
         .sum_z  (acc_sz[gi]),
         .count  (acc_cnt[gi]),
         .sat    (sat[gi])
      );
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      tag_d   = tag_q;
      case (state_q)
         ACCUM: begin
            // End marker wins over the centroid-load flag on the same beat.
            if (in_hs && in_bits_pointsFinished) begin
               tag_d   = in_tag;
               ptr_d   = '0;
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (out_hs) begin
               ptr_d = ptr_q + 1'b1;
               if (is_last) begin
                  ptr_d   = '0;
                  state_d = ACCUM;
               end
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ACCUM;
         ptr_q   <= '0;
         tag_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         tag_q   <= tag_d;
      end
   end

   assign out_bits_centeroidIndex = draining ? IDX_W'(ptr_q) : '0;
   assign out_bits_sum_x          = draining ? acc_sx[ptr_q] : '0;
   assign out_bits_sum_y          = draining ? acc_sy[ptr_q] : '0;
   assign out_bits_sum_z          = draining ? acc_sz[ptr_q] : '0;
   assign out_bits_count          = draining ? acc_cnt[ptr_q] : '0;
   assign out_bits_last           = draining & is_last;
   assign out_tag                 = tag_q;

`ifdef KMEANS_COLLECT_DROP_CNT_EN
   logic        in_range, sat_hit, drop;
   logic [15:0] drop_q, drop_d;

   assign in_range = |hit;
   assign sat_hit  = |(hit & sat);
   assign drop     = pt_beat & (~in_range | sat_hit);

   always_comb begin
      drop_d = drop_q;
      if (drop && (drop_q != 16'hFFFF)) begin
         drop_d = drop_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         drop_q <= '0;
      end else begin
         drop_q <= drop_d;
      end
   end

   assign drop_count = drop_q;
`else
   assign drop_count = '0;
`endif

endmodule

// File: tb/tb_kmeans_result_collector.sv
// Randomized self-checking bench for kmeans_result_collector against a per-centroid sum/count model.
module tb_kmeans_result_collector;
   import kmeans_collect_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               reset;
   logic               in_valid, in_ready, in_cf, in_pf;
   logic [15:0]        in_idx;
   logic signed [63:0] in_x, in_y, in_z;
   logic [3:0]         in_tag;
   logic               out_valid, out_ready;
   logic [15:0]        out_idx;
   logic signed [79:0] out_sx, out_sy, out_sz;
   logic [15:0]        out_cnt;
   logic               out_last;
   logic [3:0]         out_tag;
   logic [15:0]        drop_count;

   kmeans_result_collector dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_bits_centeroidsFinished(in_cf), .in_bits_pointsFinished(in_pf),
      .in_bits_centeroidIndex(in_idx),
      .in_bits_point_x(in_x), .in_bits_point_y(in_y), .in_bits_point_z(in_z),
      .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_bits_centeroidIndex(out_idx),
      .out_bits_sum_x(out_sx), .out_bits_sum_y(out_sy), .out_bits_sum_z(out_sz),
      .out_bits_count(out_cnt), .out_bits_last(out_last),
      .out_tag(out_tag), .drop_count(drop_count)
   );

   // Narrow-count instance: 4 entries, 2-bit counts.
   logic               d2_in_valid, d2_in_ready, d2_in_pf;
   logic [15:0]        d2_in_idx;
   logic [63:0]        d2_in_x, d2_in_y;
   logic [3:0]         d2_in_tag;
   logic               d2_out_valid, d2_out_ready;
   logic [15:0]        d2_out_idx;
   logic [65:0]        d2_out_sx, d2_out_sy, d2_out_sz;
   logic [1:0]         d2_out_cnt;
   logic               d2_out_last;
   logic [3:0]         d2_out_tag;
   logic [15:0]        d2_drop_count;

   kmeans_result_collector #(.NUM_CENTROIDS(4), .CNT_W(2), .SUM_W(66)) dut2 (
      .clk(clk), .reset(reset),
      .in_valid(d2_in_valid), .in_ready(d2_in_ready),
      .in_bits_centeroidsFinished(1'b0), .in_bits_pointsFinished(d2_in_pf),
      .in_bits_centeroidIndex(d2_in_idx),
      .in_bits_point_x(d2_in_x), .in_bits_point_y(d2_in_y), .in_bits_point_z(64'd0),
      .in_tag(d2_in_tag),
      .out_valid(d2_out_valid), .out_ready(d2_out_ready),
      .out_bits_centeroidIndex(d2_out_idx),
      .out_bits_sum_x(d2_out_sx), .out_bits_sum_y(d2_out_sy), .out_bits_sum_z(d2_out_sz),
      .out_bits_count(d2_out_cnt), .out_bits_last(d2_out_last),
      .out_tag(d2_out_tag), .drop_count(d2_drop_count)
   );

   int tests = 0;
   int fails = 0;

   // Reference model: what each centroid entry should hold right now.
   logic signed [79:0] m_sx [8];
   logic signed [79:0] m_sy [8];
   logic signed [79:0] m_sz [8];
   int                 m_cnt [8];
   int                 m_drops;
   logic [3:0]         m_tag;

   task automatic check(input string name, input logic [79:0] obs, input logic [79:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 8; i++) begin
         m_sx[i] = '0; m_sy[i] = '0; m_sz[i] = '0; m_cnt[i] = 0;
      end
   endtask

   function automatic logic [15:0] exp_drops();
`ifdef KMEANS_COLLECT_DROP_CNT_EN
      return (m_drops > 65535) ? 16'hFFFF : 16'(m_drops);
`else
      return 16'h0000;
`endif
   endfunction

   task automatic send_beat(input bit pf, input bit cf, input logic [15:0] idx,
                            input logic signed [63:0] x, input logic signed [63:0] y,
                            input logic signed [63:0] z, input logic [3:0] tag);
      int n = 0;
      in_valid = 1'b1; in_pf = pf; in_cf = cf; in_idx = idx;
      in_x = x; in_y = y; in_z = z; in_tag = tag;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         check("in_ready_wait", 80'(in_ready), 80'(1));
      end else begin
         if (pf) m_tag = tag;
         else if (!cf) begin
            if (idx >= 16'd8 || m_cnt[idx] == 65535) m_drops++;
            else begin
               m_sx[idx] += x; m_sy[idx] += y; m_sz[idx] += z;
               m_cnt[idx]++;
            end
         end
         @(negedge clk);
      end
      in_valid = 1'b0; in_pf = 1'b0; in_cf = 1'b0;
      $display("[TB] beat pf=%0d cf=%0d idx=%0d tag=%0d", pf, cf, idx, tag);
   endtask

   // mode 0: ready always high; 1: ready pattern 1,0,0,1; 2: random ready.
   task automatic drain(input int mode);
      int got = 0;
      int cyc = 0;
      bit r;
      bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      summary_beat_t e;
      while (got < 8 && cyc < 200) begin
         r = (mode == 0) ? 1'b1 : (mode == 1) ? pat[cyc % 4] : 1'($urandom_range(0, 1));
         out_ready = r;
         e.idx = 16'(got); e.sum_x = m_sx[got]; e.sum_y = m_sy[got]; e.sum_z = m_sz[got];
         e.count = 16'(m_cnt[got]); e.last = (got == 7); e.tag = m_tag;
         check("out_valid", 80'(out_valid), 80'(1));
         check("out_idx", 80'(out_idx), 80'(e.idx));
         check("sum_x", out_sx, e.sum_x);
         check("sum_y", out_sy, e.sum_y);
         check("sum_z", out_sz, e.sum_z);
         check("count", 80'(out_cnt), 80'(e.count));
         check("last", 80'(out_last), 80'(e.last));
         check("out_tag", 80'(out_tag), 80'(e.tag));
         if (r) begin
            $display("[TB] drain idx=%0d count=%0d sum_x=%0d last=%0d", out_idx, out_cnt, out_sx, out_last);
            m_sx[got] = '0; m_sy[got] = '0; m_sz[got] = '0; m_cnt[got] = 0;
            got++;
         end
         @(negedge clk);
         cyc++;
      end
      out_ready = 1'b0;
      check("drain_beats", 80'(got), 80'(8));
      check("in_ready_after_drain", 80'(in_ready), 80'(1));
      check("out_valid_after_drain", 80'(out_valid), 80'(0));
   endtask

   task automatic random_round(input int n);
      logic [15:0] idx;
      for (int i = 0; i < n; i++) begin
         idx = 16'($urandom_range(0, 9));
         send_beat(1'b0, ($urandom_range(0, 7) == 0), idx,
                   {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 4'(i));
      end
   endtask

   initial begin
      logic [65:0] e2;
      reset = 1'b1; in_valid = 1'b0; in_pf = 1'b0; in_cf = 1'b0; in_idx = '0;
      in_x = '0; in_y = '0; in_z = '0; in_tag = '0; out_ready = 1'b0;
      d2_in_valid = 1'b0; d2_in_pf = 1'b0; d2_in_idx = '0; d2_in_x = '0; d2_in_y = '0;
      d2_in_tag = '0; d2_out_ready = 1'b0;
      model_clear(); m_drops = 0; m_tag = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 80'(in_ready), 80'(1));
      check("rst_out_valid", 80'(out_valid), 80'(0));
      check("rst_out_idx", 80'(out_idx), 80'(0));
      check("rst_sum_x", out_sx, 80'(0));
      check("rst_count", 80'(out_cnt), 80'(0));
      check("rst_last", 80'(out_last), 80'(0));
      check("rst_tag", 80'(out_tag), 80'(0));
      check("rst_drop", 80'(drop_count), 80'(0));
      reset = 1'b0;

      // Directed round from the basic scenario.
      send_beat(0, 0, 16'd0, 64'sd1, 64'sd2, 64'sd3, 4'd0);
      send_beat(0, 0, 16'd0, 64'sd4, 64'sd5, 64'sd6, 4'd0);
      send_beat(0, 0, 16'd3, -64'sd1, -64'sd1, -64'sd1, 4'd0);
      send_beat(1, 0, 16'd0, 64'sd0, 64'sd0, 64'sd0, 4'd5);
      check("first_beat_valid", 80'(out_valid), 80'(1));
      drain(0);

      // Out-of-range index, then a marker carrying both flags.
      send_beat(0, 0, 16'd9, 64'sd7, 64'sd7, 64'sd7, 4'd0);
      check("drop_idx9", 80'(drop_count), 80'(exp_drops()));
      send_beat(0, 0, 16'd2, 64'sd11, -64'sd12, 64'sd13, 4'd0);
      send_beat(1, 1, 16'd2, 64'sd99, 64'sd99, 64'sd99, 4'd6);
      check("both_flags_in_ready", 80'(in_ready), 80'(0));
      drain(1);

      // Random rounds; the second drain must show only the newer data.
      random_round(30);
      check("drop_rand1", 80'(drop_count), 80'(exp_drops()));
      send_beat(1, 0, 16'd0, 64'sd0, 64'sd0, 64'sd0, 4'($urandom));
      drain(2);
      random_round(20);
      send_beat(1, 0, 16'd0, 64'sd0, 64'sd0, 64'sd0, 4'($urandom));
      drain(1);
      check("drop_rand2", 80'(drop_count), 80'(exp_drops()));

      // Reset on the third drain beat.
      random_round(10);
      send_beat(1, 0, 16'd0, 64'sd0, 64'sd0, 64'sd0, 4'd12);
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("pre_reset_idx", 80'(out_idx), 80'(2));
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      out_ready = 1'b0;
      model_clear(); m_drops = 0; m_tag = '0;
      check("mid_rst_out_valid", 80'(out_valid), 80'(0));
      check("mid_rst_in_ready", 80'(in_ready), 80'(1));
      check("mid_rst_drop", 80'(drop_count), 80'(0));
      send_beat(1, 0, 16'd0, 64'sd0, 64'sd0, 64'sd0, 4'd3);
      drain(0);

      // Narrow-count instance: fourth point to idx1 saturates and is dropped.
      for (int k = 1; k <= 4; k++) begin
         d2_in_valid = 1'b1; d2_in_idx = 16'd1;
         d2_in_x = 64'(10 * k); d2_in_y = -64'(k);
         @(negedge clk);
         $display("[TB] d2 beat idx=1 x=%0d in_ready=%0d", 10 * k, d2_in_ready);
      end
      d2_in_pf = 1'b1; d2_in_tag = 4'd9;
      @(negedge clk);
      d2_in_valid = 1'b0; d2_in_pf = 1'b0;
`ifdef KMEANS_COLLECT_DROP_CNT_EN
      check("d2_drop", 80'(d2_drop_count), 80'(1));
`else
      check("d2_drop", 80'(d2_drop_count), 80'(0));
`endif
      d2_out_ready = 1'b1;
      for (int e = 0; e < 4; e++) begin
         check("d2_valid", 80'(d2_out_valid), 80'(1));
         check("d2_idx", 80'(d2_out_idx), 80'(e));
         check("d2_count", 80'(d2_out_cnt), (e == 1) ? 80'(3) : 80'(0));
         e2 = (e == 1) ? 66'd60 : 66'd0;
         check("d2_sum_x", 80'(d2_out_sx), 80'(e2));
         e2 = (e == 1) ? -66'sd6 : 66'd0;
         check("d2_sum_y", 80'(d2_out_sy), 80'(e2));
         check("d2_last", 80'(d2_out_last), 80'(e == 3));
         check("d2_tag", 80'(d2_out_tag), 80'(9));
         $display("[TB] d2 drain idx=%0d count=%0d sum_x=%0d", d2_out_idx, d2_out_cnt, d2_out_sx);
         @(negedge clk);
      end
      d2_out_ready = 1'b0;
      check("d2_in_ready_after", 80'(d2_in_ready), 80'(1));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
